// File: rtl/fb_plot_sink.sv
// 3-bit framebuffer fed by a pixel-plot port and a full-screen fill engine,
// with a free-running raster readout port (1-cycle latency, read-before-write).
module fb_plot_sink #(
  parameter int FB_W = 160,
  parameter int FB_H = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       plot,
  input  logic [7:0] plot_x,
  input  logic [6:0] plot_y,
  input  logic [2:0] plot_colour,
  input  logic       clear_start,
  input  logic [2:0] clear_colour,
  output logic       clear_busy,
  output logic       clear_done,
  input  logic       scan_en,
  output logic       scan_valid,
  output logic [7:0] scan_x,
  output logic [6:0] scan_y,
  output logic [2:0] scan_colour,
  output logic       scan_sof,
  output logic [7:0] drop_count
);
  localparam int DEPTH = FB_W * FB_H;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   fill_addr_q;
  logic [2:0]      fill_col_q;
  logic            fill_last;
  logic            plot_in_range, plot_ok, plot_drop;
  logic            we;
  logic [AW-1:0]   waddr, raddr;
  logic [2:0]      wdata;
  logic [7:0]      rx_q;
  logic [6:0]      ry_q;
  logic [2:0]      mem [DEPTH];

  function automatic logic [AW-1:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    return AW'(int'(y) * FB_W + int'(x));
  endfunction

  assign fill_last = (fill_addr_q == AW'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (clear_start) state_d = CLEAR;
      CLEAR:   if (fill_last)   state_d = DONE;
      DONE:    if (!clear_start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fill_addr_q <= '0;
      fill_col_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && clear_start) begin
        fill_addr_q <= '0;
        fill_col_q  <= clear_colour;
      end else if (state_q == CLEAR) begin
        fill_addr_q <= fill_addr_q + 1'b1;
      end
    end
  end

  assign clear_busy = (state_q == CLEAR);
  assign clear_done = (state_q == DONE);

  // Plots are invisible while filling: neither written nor counted as drops.
  assign plot_in_range = (32'(plot_x) < FB_W) && (32'(plot_y) < FB_H);
  assign plot_ok       = plot && (state_q != CLEAR) && plot_in_range;
  assign plot_drop     = plot && (state_q != CLEAR) && !plot_in_range;

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (state_q == CLEAR) begin
      we    = 1'b1;
      waddr = fill_addr_q;
      wdata = fill_col_q;
    end else if (plot_ok) begin
      we    = 1'b1;
      waddr = pix_addr(plot_x, plot_y);
      wdata = plot_colour;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (plot_drop && drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_q <= '0;
      ry_q <= '0;
    end else if (scan_en) begin
      if (rx_q == 8'(FB_W - 1)) begin
        rx_q <= '0;
        ry_q <= (ry_q == 7'(FB_H - 1)) ? '0 : ry_q + 7'd1;
      end else begin
        rx_q <= rx_q + 8'd1;
      end
    end
  end

  assign raddr = pix_addr(rx_q, ry_q);

  // Registered read in its own process from the write, so a same-cycle
  // write to the scanned pixel returns the old contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_valid  <= 1'b0;
      scan_x      <= '0;
      scan_y      <= '0;
      scan_colour <= '0;
      scan_sof    <= 1'b0;
    end else begin
      scan_valid <= scan_en;
      scan_sof   <= scan_en && rx_q == '0 && ry_q == '0;
      if (scan_en) begin
        scan_x      <= rx_q;
        scan_y      <= ry_q;
        scan_colour <= mem[raddr];
      end
    end
  end
endmodule

// File: tb/tb_fb_plot_sink.sv
// Scoreboarded bench for fb_plot_sink: a reference model queues expected
// scan pixels as scan_en is driven; a negedge monitor pops and compares.
module tb_fb_plot_sink;
  localparam int FB_W = 160;
  localparam int FB_H = 120;
  localparam int NPIX = FB_W * FB_H;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       plot;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_colour;
  logic       clear_start;
  logic [2:0] clear_colour;
  logic       clear_busy, clear_done;
  logic       scan_en, scan_valid, scan_sof;
  logic [7:0] scan_x;
  logic [6:0] scan_y;
  logic [2:0] scan_colour;
  logic [7:0] drop_count;

  fb_plot_sink #(.FB_W(FB_W), .FB_H(FB_H)) dut (
    .clk(clk), .rst_n(rst_n),
    .plot(plot), .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
    .clear_start(clear_start), .clear_colour(clear_colour),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .scan_en(scan_en), .scan_valid(scan_valid),
    .scan_x(scan_x), .scan_y(scan_y), .scan_colour(scan_colour),
    .scan_sof(scan_sof), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int sof_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       k;
  } exp_t;
  exp_t sb_q[$];

  typedef enum {M_IDLE, M_CLEAR, M_DONE} mst_t;
  mst_t       m_st;
  logic [2:0] m_mem   [NPIX];
  bit         m_known [NPIX];
  int         m_fa, m_rx, m_ry;
  logic [2:0] m_fc;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_st <= M_IDLE;
      m_rx <= 0;
      m_ry <= 0;
    end else begin
      if (scan_en) begin
        sb_q.push_back({8'(m_rx), 7'(m_ry), m_mem[m_ry*FB_W+m_rx], m_known[m_ry*FB_W+m_rx]});
        if (m_rx == FB_W - 1) begin
          m_rx <= 0;
          m_ry <= (m_ry == FB_H - 1) ? 0 : m_ry + 1;
        end else begin
          m_rx <= m_rx + 1;
        end
      end
      case (m_st)
        M_IDLE: if (clear_start) begin
          m_st <= M_CLEAR;
          m_fa <= 0;
          m_fc <= clear_colour;
        end
        M_CLEAR: begin
          m_mem[m_fa]   <= m_fc;
          m_known[m_fa] <= 1'b1;
          m_fa          <= m_fa + 1;
          if (m_fa == NPIX - 1) m_st <= M_DONE;
        end
        M_DONE: if (!clear_start) m_st <= M_IDLE;
        default: m_st <= M_IDLE;
      endcase
      if (m_st != M_CLEAR && plot && plot_x < FB_W && plot_y < FB_H) begin
        m_mem[int'(plot_y)*FB_W+int'(plot_x)]   <= plot_colour;
        m_known[int'(plot_y)*FB_W+int'(plot_x)] <= 1'b1;
      end
    end
  end

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (scan_sof) sof_cnt++;
    if (scan_valid) begin
      if (sb_q.size() == 0) begin
        chk("scan_valid_extra", 32'(scan_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("scan_x", 32'(scan_x), 32'(e.x));
        chk("scan_y", 32'(scan_y), 32'(e.y));
        if (e.k) chk("scan_colour", 32'(scan_colour), 32'(e.c));
        chk("scan_sof", 32'(scan_sof), 32'(e.x == 0 && e.y == 0));
      end
    end else if (sb_q.size() != 0) begin
      chk("scan_valid_missing", 32'(scan_valid), 32'd1);
      void'(sb_q.pop_front());
    end
  end

  // Full fill: counts busy cycles, checks DONE holds while clear_start is high.
  task automatic run_clear(input logic [2:0] col, input bit scan, input bit plot_mid,
                           input string tag, output int sofs);
    int n, sof0;
    clear_colour = col;
    clear_start  = 1'b1;
    scan_en      = scan;
    sof0         = sof_cnt;
    step(1);
    n = 0;
    while (clear_busy === 1'b1 && n < NPIX + 1000) begin
      n++;
      if (plot_mid && n == 100) begin
        plot = 1'b1; plot_x = 8'd10; plot_y = 7'd10; plot_colour = 3'b111;
      end else begin
        plot = 1'b0;
      end
      step(1);
    end
    sofs    = sof_cnt - sof0;
    scan_en = 1'b0;
    plot    = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(n), 32'(NPIX));
    chk({tag, "_done"}, 32'(clear_done), 32'd1);
    step(3);
    chk({tag, "_done_held"}, 32'(clear_done), 32'd1);
    chk({tag, "_no_refill"}, 32'(clear_busy), 32'd0);
    clear_start = 1'b0;
    step(1);
    chk({tag, "_done_release"}, 32'(clear_done), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sofs, n;
    rst_n = 1'b0; plot = 1'b0; plot_x = '0; plot_y = '0; plot_colour = '0;
    clear_start = 1'b0; clear_colour = '0; scan_en = 1'b0;
    step(3);
    chk("rst_busy", 32'(clear_busy), 32'd0);
    chk("rst_done", 32'(clear_done), 32'd0);
    chk("rst_valid", 32'(scan_valid), 32'd0);
    chk("rst_sof", 32'(scan_sof), 32'd0);
    chk("rst_xy", {17'd0, scan_x, scan_y}, 32'd0);
    chk("rst_colour", 32'(scan_colour), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    rst_n = 1'b1;
    step(1);

    // Fill with 010; the next fill's scan runs ahead of its writes, so it
    // reads back the 010 frame in full.
    run_clear(3'b010, 1'b0, 1'b0, "clr010", sofs);
    run_clear(3'b000, 1'b1, 1'b1, "clr000", sofs);
    chk("sof_per_frame", 32'(sofs), 32'd1);
    chk("drop_after_clear_plot", 32'(drop_count), 32'd0);

    // Corner plots, then a full frame checks 5/7 at corners, 0 elsewhere.
    plot = 1'b1; plot_x = 8'd159; plot_y = 7'd119; plot_colour = 3'b101;
    step(1);
    plot_x = 8'd0; plot_y = 7'd0; plot_colour = 3'b111;
    step(1);
    plot = 1'b0;
    chk("drop_in_range", 32'(drop_count), 32'd0);
    scan_en = 1'b1;
    step(NPIX);
    scan_en = 1'b0;
    step(2);

    // Collision at pixel 0: reset re-homes the raster onto (0,0).
    plot = 1'b1; plot_x = 8'd0; plot_y = 7'd0; plot_colour = 3'b110;
    step(1);
    plot = 1'b0; rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("rst2_valid", 32'(scan_valid), 32'd0);
    scan_en = 1'b1; plot = 1'b1; plot_colour = 3'b001;
    step(1);
    scan_en = 1'b0; plot = 1'b0;
    chk("coll_old", 32'(scan_colour), 32'd6);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1; scan_en = 1'b1;
    step(1);
    scan_en = 1'b0;
    chk("coll_new", 32'(scan_colour), 32'd1);

    // Out-of-range plots: count saturates; a short scan covers aliased pixels.
    for (int i = 0; i < 300; i++) begin
      plot = 1'b1; plot_colour = 3'b111;
      case (i % 3)
        0:       begin plot_x = 8'd160; plot_y = 7'd0;   end
        1:       begin plot_x = 8'd0;   plot_y = 7'd120; end
        default: begin plot_x = 8'd255; plot_y = 7'd127; end
      endcase
      step(1);
      if (i == 253) chk("drop_254", 32'(drop_count), 32'd254);
    end
    plot = 1'b0;
    chk("drop_sat", 32'(drop_count), 32'd255);
    scan_en = 1'b1;
    step(200);
    scan_en = 1'b0;
    step(2);

    // Reset mid-fill aborts; a new fill takes a full frame from address 0.
    clear_colour = 3'b011; clear_start = 1'b1;
    step(1);
    n = 0;
    while (clear_busy === 1'b1 && n < 5000) begin
      n++;
      step(1);
    end
    chk("abort_reached", 32'(n), 32'd5000);
    rst_n = 1'b0; clear_start = 1'b0;
    step(1);
    chk("abort_busy", 32'(clear_busy), 32'd0);
    chk("abort_done", 32'(clear_done), 32'd0);
    rst_n = 1'b1;
    step(1);
    run_clear(3'b100, 1'b0, 1'b0, "refill", sofs);

    step(2);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fb_plot_sink.md
FB_PLOT_SINK -- requirements
Module: fb_plot_sink

Interface
REQ-001 SHALL have parameter FB_W, default 160, framebuffer width in pixels.
REQ-002 SHALL have parameter FB_H, default 120, framebuffer height in pixels.
REQ-003 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port plot, input, 1, pixel write strobe from a drawing engine.
REQ-006 SHALL have port plot_x, input, 8, write column.
REQ-007 SHALL have port plot_y, input, 7, write row.
REQ-008 SHALL have port plot_colour, input, 3, write colour.
REQ-009 SHALL have port clear_start, input, 1, level request to fill the whole framebuffer.
REQ-010 SHALL have port clear_colour, input, 3, fill colour, sampled on the IDLE->CLEAR transition.
REQ-011 SHALL have port clear_busy, output, 1, high while the fill engine is writing.
REQ-012 SHALL have port clear_done, output, 1, fill complete, held until clear_start deasserts.
REQ-013 SHALL have port scan_en, input, 1, raster readout advance enable.
REQ-014 SHALL have port scan_valid, output, 1, scan_x/scan_y/scan_colour are valid this cycle.
REQ-015 SHALL have ports scan_x (output, 8), scan_y (output, 7), scan_colour (output, 3): readout pixel.
REQ-016 SHALL have port scan_sof, output, 1, high with the valid pixel (0,0).
REQ-017 SHALL have port drop_count, output, 8, saturating count of rejected out-of-range plots.

Function
REQ-018 SHALL store FB_W*FB_H 3-bit pixels; address = y*FB_W + x (15 bits, 0..19199 at defaults).
REQ-019 SHALL, with FSM in IDLE or DONE, write plot_colour at (plot_x,plot_y) at the edge where plot=1, plot_x<FB_W and plot_y<FB_H.
REQ-020 SHALL drop a plot with plot_x>=FB_W or plot_y>=FB_H, increment drop_count by 1 and hold it at 255 once reached.
REQ-021 SHALL ignore plot entirely while in CLEAR: no write and no drop_count change.
REQ-022 SHALL implement fill FSM states IDLE, CLEAR, DONE; IDLE->CLEAR when clear_start=1, and clear the fill address to 0 and latch clear_colour on that transition.
REQ-023 SHALL in CLEAR write the latched colour at one address per cycle, ascending 0..FB_W*FB_H-1, and go CLEAR->DONE after writing the last address (19200 CLEAR cycles at defaults).
REQ-024 SHALL drive clear_busy=1 exactly while in CLEAR and clear_done=1 exactly while in DONE.
REQ-025 SHALL go DONE->IDLE when clear_start=0; DONE SHALL remain while clear_start=1, and no refill occurs without a low-then-high cycle on clear_start.
REQ-026 SHALL keep a raster counter (rx,ry) that advances by one pixel on each cycle with scan_en=1: rx 0..FB_W-1; rx wraps to 0 with ry+1; (FB_W-1,FB_H-1) wraps to (0,0).
REQ-027 SHALL hold the raster counter when scan_en=0, and SHALL keep it running during CLEAR.
REQ-028 SHALL present readout with one-cycle latency: scan_valid at cycle N+1 equals scan_en at cycle N; scan_x/scan_y equal rx/ry at N; scan_colour is the memory contents at that address before any write made in cycle N (read-before-write).
REQ-029 SHALL drive scan_sof=1 only when scan_valid=1 and scan_x=0 and scan_y=0.
REQ-030 SHALL give a write in cycle N priority over nothing else: at most one write source per cycle (fill in CLEAR, else plot).

Reset
REQ-031 SHALL on rst_n=0 set FSM=IDLE, fill address=0, raster counter=(0,0), drop_count=0, and clear_busy, clear_done, scan_valid, scan_sof, scan_x, scan_y, scan_colour all 0.
REQ-032 SHALL NOT reset memory contents; pixel values are undefined until written or cleared.
REQ-033 SHALL abort an in-progress fill on reset (FSM to IDLE; pixels already filled keep their value).

Verification
REQ-034 Clear: clear_colour=3'b010, pulse clear_start high -> clear_busy high 19200 cycles, then clear_done; full scan returns 3'b010 at all 19200 pixels; sof once per frame.
REQ-035 Plot: after clear to 0, plot (159,119,3'b101) and (0,0,3'b111) -> scan_colour 5 at (159,119), 7 at (0,0), 0 elsewhere; drop_count=0.
REQ-036 Range: plots at (160,0), (0,120), (255,127), 300 total -> no memory change, drop_count saturates at 255.
REQ-037 Plot during clear: plot (10,10,3'b111) while clear_busy=1 -> after fill, pixel (10,10) equals clear colour; drop_count unchanged.
REQ-038 Collision: scan reads address 0 in the same cycle as a plot writes (0,0,3'b001) over old value 3'b110 -> scan_colour=3'b110 that frame, 3'b001 on the next frame.
REQ-039 Reset mid-fill: rst_n=0 at fill address 5000 -> clear_busy=0, clear_done=0 next cycle; new clear_start restarts at address 0 and takes a full 19200 cycles.
